// File: rtl/stb_cmd_issuer.sv
// stb_cmd_issuer: command FIFO plus one-at-a-time issuer for the store-burst
// top level. Commands are queued, issued as a single-cycle stb_u_valid pulse,
// and the issuer waits for stb_d_valid && stb_d_done (or a timeout) before
// it moves on to the next command.
// Optional build macro: STB_CMD_FILTER_EN. When it is defined, queued commands
// whose SMC mask or byte-enable code is zero are discarded and counted in
// drop_count instead of being issued.
module stb_cmd_issuer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int SMC_COUNT      = 6,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SMC_COUNT-1:0]      cmd_smc_strb,
    input  logic [3:0]                cmd_byte_strb,
    input  logic [1:0]                cmd_brst,
    input  logic [ADDR_WIDTH-1:0]     cmd_gr_base_addr,
    input  logic [3:0]                cmd_ur_id,
    input  logic [10:0]               cmd_ur_addr,
    output logic                      stb_u_valid,
    output logic [SMC_COUNT-1:0]      stb_u_smc_strb,
    output logic [3:0]                stb_u_byte_strb,
    output logic [1:0]                stb_u_brst,
    output logic [ADDR_WIDTH-1:0]     stb_u_gr_base_addr,
    output logic [3:0]                stb_u_ur_id,
    output logic [10:0]               stb_u_ur_addr,
    input  logic                      stb_d_valid,
    input  logic                      stb_d_done,
    output logic                      stb_d_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      busy,
    output logic [15:0]               done_count,
    output logic [15:0]               drop_count,
    output logic                      timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [SMC_COUNT-1:0]  smc_strb;
        logic [3:0]            byte_strb;
        logic [1:0]            brst;
        logic [ADDR_WIDTH-1:0] gr_base_addr;
        logic [3:0]            ur_id;
        logic [10:0]           ur_addr;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    cmd_t             fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             cmd_ready_r;

    state_t           state_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    cmd_t             issue_r;
    logic             stb_u_valid_r;
    logic             stb_d_ready_r;
    logic [15:0]      done_count_r;
    logic             timeout_err_r;

    cmd_t             cmd_in_s;
    cmd_t             head_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    assign cmd_in_s = '{smc_strb:     cmd_smc_strb,
                        byte_strb:    cmd_byte_strb,
                        brst:         cmd_brst,
                        gr_base_addr: cmd_gr_base_addr,
                        ur_id:        cmd_ur_id,
                        ur_addr:      cmd_ur_addr};
    assign head_s   = fifo_mem_r[rd_ptr_r];

    // The only pop point is IDLE with a non-empty queue; a full queue never accepts.
    assign push_s = cmd_valid && cmd_ready_r;
    assign pop_s  = (state_r == ST_IDLE) && (count_r != '0);

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Decide whether the head being popped is discarded instead of issued.
    always_comb begin
        drop_s = 1'b0;
`ifdef STB_CMD_FILTER_EN
        if (pop_s && ((head_s.smc_strb == '0) || (head_s.byte_strb == 4'h0))) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
`endif
    end

    // FIFO storage: data only, pointers guard validity so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= cmd_in_s;
        end
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            cmd_ready_r <= (count_nxt_s != CNT_W'(DEPTH));
        end
    end

    // Issue FSM with registered issue pulse, completion accept and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= '0;
            issue_r       <= '0;
            stb_u_valid_r <= 1'b0;
            stb_d_ready_r <= 1'b0;
            done_count_r  <= 16'h0000;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stb_u_valid_r <= 1'b0;
                    stb_d_ready_r <= 1'b0;
                    if (pop_s && !drop_s) begin
                        issue_r       <= head_s;
                        stb_u_valid_r <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stb_u_valid_r <= 1'b0;
                    stb_d_ready_r <= 1'b1;
                    tmo_cnt_r     <= '0;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (stb_d_valid && stb_d_done) begin
                        done_count_r  <= done_count_r + 16'd1;
                        stb_d_ready_r <= 1'b0;
                        state_r       <= ST_GAP;
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_r <= 1'b1;
                        stb_d_ready_r <= 1'b0;
                        state_r       <= ST_GAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    stb_u_valid_r <= 1'b0;
                    stb_d_ready_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    stb_u_valid_r <= 1'b0;
                    stb_d_ready_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STB_CMD_FILTER_EN
    logic [15:0] drop_count_r;

    // Count discarded heads; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_r <= 16'h0000;
        end else if (drop_s) begin
            drop_count_r <= drop_count_r + 16'd1;
        end
    end

    assign drop_count = drop_count_r;
`else
    assign drop_count = 16'h0000;
`endif

    assign cmd_ready          = cmd_ready_r;
    assign fifo_count         = count_r;
    assign busy               = (state_r != ST_IDLE) || (count_r != '0);
    assign stb_u_valid        = stb_u_valid_r;
    assign stb_u_smc_strb     = issue_r.smc_strb;
    assign stb_u_byte_strb    = issue_r.byte_strb;
    assign stb_u_brst         = issue_r.brst;
    assign stb_u_gr_base_addr = issue_r.gr_base_addr;
    assign stb_u_ur_id        = issue_r.ur_id;
    assign stb_u_ur_addr      = issue_r.ur_addr;
    assign stb_d_ready        = stb_d_ready_r;
    assign done_count         = done_count_r;
    assign timeout_err        = timeout_err_r;

endmodule

// File: tb/tb_stb_cmd_issuer.sv
// Self-checking bench for stb_cmd_issuer: directed steps plus a randomized
// stream checked against a queue-based reference (push order, completion
// count, drop rule).
module tb_stb_cmd_issuer;

    localparam int AW    = 32;
    localparam int SC    = 6;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [SC-1:0] smc;
        logic [3:0]    bs;
        logic [1:0]    brst;
        logic [AW-1:0] addr;
        logic [3:0]    id;
        logic [10:0]   ua;
    } cmd_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [SC-1:0]   cmd_smc_strb = '0;
    logic [3:0]      cmd_byte_strb = 4'h0;
    logic [1:0]      cmd_brst = 2'b00;
    logic [AW-1:0]   cmd_gr_base_addr = '0;
    logic [3:0]      cmd_ur_id = 4'h0;
    logic [10:0]     cmd_ur_addr = 11'h000;
    logic            stb_u_valid;
    logic [SC-1:0]   stb_u_smc_strb;
    logic [3:0]      stb_u_byte_strb;
    logic [1:0]      stb_u_brst;
    logic [AW-1:0]   stb_u_gr_base_addr;
    logic [3:0]      stb_u_ur_id;
    logic [10:0]     stb_u_ur_addr;
    logic            stb_d_valid;
    logic            stb_d_done;
    logic            stb_d_ready;
    logic [3:0]      fifo_count;
    logic            busy;
    logic [15:0]     done_count;
    logic [15:0]     drop_count;
    logic            timeout_err;

    logic resp_v = 1'b0, resp_d = 1'b0, man_v = 1'b0, man_d = 1'b0;
    assign stb_d_valid = resp_v | man_v;
    assign stb_d_done  = resp_d | man_d;

    always #5 clk = ~clk;

    stb_cmd_issuer #(
        .ADDR_WIDTH(AW), .SMC_COUNT(SC), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_smc_strb(cmd_smc_strb), .cmd_byte_strb(cmd_byte_strb),
        .cmd_brst(cmd_brst), .cmd_gr_base_addr(cmd_gr_base_addr),
        .cmd_ur_id(cmd_ur_id), .cmd_ur_addr(cmd_ur_addr),
        .stb_u_valid(stb_u_valid), .stb_u_smc_strb(stb_u_smc_strb),
        .stb_u_byte_strb(stb_u_byte_strb), .stb_u_brst(stb_u_brst),
        .stb_u_gr_base_addr(stb_u_gr_base_addr), .stb_u_ur_id(stb_u_ur_id),
        .stb_u_ur_addr(stb_u_ur_addr),
        .stb_d_valid(stb_d_valid), .stb_d_done(stb_d_done), .stb_d_ready(stb_d_ready),
        .fifo_count(fifo_count), .busy(busy), .done_count(done_count),
        .drop_count(drop_count), .timeout_err(timeout_err)
    );

    cmd_t obs_cmd;
    assign obs_cmd = '{smc: stb_u_smc_strb, bs: stb_u_byte_strb, brst: stb_u_brst,
                       addr: stb_u_gr_base_addr, id: stb_u_ur_id, ua: stb_u_ur_addr};

    int   total = 0;
    int   passed = 0;
    int   exp_done = 0;
    int   exp_drop = 0;
    cmd_t exp_q[$];
    cmd_t issued_q[$];
    int   cyc = 0;
    int   last_issue = -100;
    int   min_gap = 1000;
    bit   resp_en = 1'b0;

    // Free-running cycle counter for pulse spacing.
    always @(posedge clk) cyc++;

    // Issue monitor: capture every stb_u_valid cycle and the spacing between them.
    always @(negedge clk) begin
        if (stb_u_valid) begin
            issued_q.push_back(obs_cmd);
            if (cyc - last_issue < min_gap) min_gap = cyc - last_issue;
            last_issue = cyc;
        end
    end

    // Completion responder: random latency 1..TMO WAIT cycles with valid-only noise.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && stb_u_valid) begin
                int lat;
                lat = $urandom_range(1, TMO);
                for (int k = 1; k <= lat; k++) begin
                    @(posedge clk); #1;
                    if (k < lat) begin
                        resp_v = ($urandom_range(0, 3) == 0);
                        resp_d = 1'b0;
                    end else begin
                        resp_v = 1'b1;
                        resp_d = 1'b1;
                    end
                end
                @(posedge clk); #1;
                resp_v = 1'b0;
                resp_d = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic bit is_dropped(input cmd_t c);
`ifdef STB_CMD_FILTER_EN
        return (c.smc == '0) || (c.bs == 4'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: issued commands appear in push order, dropped ones never do.
    function automatic void expect_cmd(input cmd_t c);
        if (is_dropped(c)) exp_drop++;
        else begin
            exp_q.push_back(c);
            exp_done++;
        end
    endfunction

    function automatic cmd_t rand_cmd(input bit allow_zero);
        cmd_t c;
        c.smc  = (allow_zero && $urandom_range(0, 4) == 0) ? '0 : SC'($urandom_range(1, 63));
        c.bs   = (allow_zero && $urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        c.brst = 2'($urandom_range(0, 3));
        c.addr = $urandom;
        c.id   = 4'($urandom_range(0, 15));
        c.ua   = 11'($urandom_range(0, 2047));
        return c;
    endfunction

    task automatic set_cmd(input cmd_t c);
        cmd_smc_strb = c.smc; cmd_byte_strb = c.bs; cmd_brst = c.brst;
        cmd_gr_base_addr = c.addr; cmd_ur_id = c.id; cmd_ur_addr = c.ua;
    endtask

    task automatic push(input cmd_t c);
        set_cmd(c); cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    endtask

    task automatic push_hs(input cmd_t c);
        int n = 0;
        set_cmd(c);
        while (!cmd_ready && n < 300) begin tick(); n++; end
        if (!cmd_ready) check("push_ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
    endtask

    task automatic complete_now();
        man_v = 1'b1; man_d = 1'b1; tick(); man_v = 1'b0; man_d = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!stb_u_valid && n < 40) begin tick(); n++; end
        check(tag, stb_u_valid, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(done_count == 16'(exp_done) && !busy) && n < 4000) begin tick(); n++; end
        check({tag, "_done"}, done_count, 64'(exp_done));
        check({tag, "_fifo"}, fifo_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drop"}, drop_count, 64'(exp_drop));
    endtask

    initial begin
        cmd_t c;
        int   isz;

        // Reset values while rst is held.
        tick(); tick();
        check("rst_status", {stb_u_valid, stb_d_ready, busy, timeout_err, fifo_count,
                             done_count, drop_count}, 0);
        check("rst_fields", obs_cmd, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // Single command, completion ten cycles after issue.
        c = '{smc: 6'h01, bs: 4'hF, brst: 2'b01, addr: 32'h0000_1000, id: 4'h3, ua: 11'h010};
        expect_cmd(c);
        push(c);
        check("lat_pop_cycle_valid", stb_u_valid, 0);
        tick();
        check("lat_issue_valid", stb_u_valid, 1);
        check("single_fields", obs_cmd, c);
        tick();
        check("single_pulse_end", stb_u_valid, 0);
        check("single_ready_wait", stb_d_ready, 1);
        repeat (8) tick();
        check("single_ready_late", stb_d_ready, 1);
        complete_now();
        check("single_done", done_count, 1);
        check("single_gap_ready", stb_d_ready, 0);
        tick();
        check("single_idle_busy", busy, 0);

        // Fill the FIFO while one command sits in WAIT.
        c = rand_cmd(1'b0); expect_cmd(c); push(c);
        wait_issue("full_first_issue");
        for (int i = 0; i < DEPTH; i++) begin
            c = rand_cmd(1'b0); expect_cmd(c); push(c);
        end
        check("full_count", fifo_count, DEPTH);
        check("full_ready", cmd_ready, 0);
        c = rand_cmd(1'b0); push(c);
        check("full_9th_rejected", fifo_count, DEPTH);
        complete_now();
        resp_en = 1'b1;
        tick(); tick();
        check("full_after_pop", fifo_count, DEPTH - 1);
        check("full_ready_back", cmd_ready, 1);
        drain("full");

        // Push and pop in the same cycle at occupancy 4.
        resp_en = 1'b0;
        c = rand_cmd(1'b0); expect_cmd(c); push(c);
        wait_issue("pp_issue");
        for (int i = 0; i < 4; i++) begin
            c = rand_cmd(1'b0); expect_cmd(c); push(c);
        end
        complete_now();
        check("pp_gap_count", fifo_count, 4);
        tick();
        c = rand_cmd(1'b0); expect_cmd(c); push(c);
        check("pp_count_held", fifo_count, 4);
        check("pp_popped", stb_u_valid, 1);
        resp_en = 1'b1;
        drain("pp");

        // Timeout: first command never completes, second one issues afterwards.
        resp_en = 1'b0;
        c = rand_cmd(1'b0); expect_cmd(c); exp_done--; push(c);
        c = rand_cmd(1'b0); expect_cmd(c); push(c);
        check("tmo_issue", stb_u_valid, 1);
        repeat (TMO) tick();
        check("tmo_not_yet", timeout_err, 0);
        tick();
        check("tmo_set", timeout_err, 1);
        check("tmo_done_unchanged", done_count, 64'(exp_done - 1));
        resp_en = 1'b1;
        drain("tmo");
        check("tmo_sticky", timeout_err, 1);

        // Completion outside WAIT is ignored.
        complete_now();
        tick();
        check("idle_completion_ignored", done_count, 64'(exp_done));

        // Randomized stream; 20+ commands also wrap the pointers several times.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            c = rand_cmd(1'b1); expect_cmd(c); push_hs(c);
        end
        drain("rand");

        // Filter pattern: zero SMC mask, valid, zero byte code, valid.
        begin
            cmd_t z;
            z = rand_cmd(1'b0); z.smc = '0;   expect_cmd(z); push(z);
            z = rand_cmd(1'b0);               expect_cmd(z); push(z);
            z = rand_cmd(1'b0); z.bs = 4'h0;  expect_cmd(z); push(z);
            z = rand_cmd(1'b0);               expect_cmd(z); push(z);
        end
        drain("filt");

        // Reset in WAIT, then a late completion must be ignored.
        resp_en = 1'b0;
        c = rand_cmd(1'b0); exp_q.push_back(c); push(c);
        c = rand_cmd(1'b0); push(c);
        c = rand_cmd(1'b0); push(c);
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("wrst_status", {stb_u_valid, stb_d_ready, busy, timeout_err, fifo_count,
                              done_count, drop_count}, 0);
        check("wrst_fields", obs_cmd, 0);
        check("wrst_cmd_ready", cmd_ready, 1);
        isz = issued_q.size();
        complete_now();
        repeat (4) tick();
        check("wrst_done_zero", done_count, 0);
        check("wrst_no_issue", 64'(issued_q.size()), 64'(isz));

        // Scoreboard: everything issued, in push order, pulses well spaced.
        check("issue_total", 64'(issued_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++) begin
            check($sformatf("issue_order_%0d", i), issued_q[i], exp_q[i]);
        end
        check("issue_spacing_ge3", 64'(min_gap >= 3), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
